// File: rtl/demux4_reg.sv
// ---------------------------------------------------------------------------
// demux4_reg -- registered 1-to-4 demultiplexer with per-channel handshakes.
//
// One input stream (din, s, in_valid/in_ready) is steered to one of four
// channels (a, b, c, d) selected by s. Each channel has a single holding
// register with its own output handshake (out_valid[k]/out_ready[k]).
// A stalled channel only blocks beats addressed to that channel.
//
// Handshake semantics (input and every output channel):
//   A beat transfers on a rising clk edge where valid & ready are both 1.
//   valid never depends on ready on the same side. The producer may change
//   din/s freely while a beat has not transferred; the values present at
//   the transfer edge are the ones taken. out_valid[k] stays high and y_k
//   stays stable until channel k's own transfer edge.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   s          in   [1:0] destination select: 0->a, 1->b, 2->c, 3->d
//   din        in   [WIDTH-1:0] input data beat
//   in_valid   in   producer offers din/s this cycle
//   in_ready   out  block accepts din this cycle (combinational)
//   y_a..y_d   out  [WIDTH-1:0] registered channel data
//   out_valid  out  [3:0] per-channel data valid, bit0=a .. bit3=d
//   out_ready  in   [3:0] per-channel consumer ready, same bit order
//   xfer_cnt   out  [7:0] count of accepted input beats, wraps 255->0
//
// out_valid is a direct view of the four channel FSM states
// (bit k = 1 <=> channel k is FULL), so it doubles as the state probe.
// ---------------------------------------------------------------------------
module demux4_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y_a,
    output logic [WIDTH-1:0] y_b,
    output logic [WIDTH-1:0] y_c,
    output logic [WIDTH-1:0] y_d,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       xfer_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           st    [4];
    logic [WIDTH-1:0] y_q   [4];
    logic [7:0]       cnt_q;

    logic       in_hs;
    logic [3:0] load;

    // The selected channel can take a beat if it is empty, or if its
    // current beat leaves on this same edge (pass-through without a bubble).
    assign in_ready = (st[s] == EMPTY) | out_ready[s];
    assign in_hs    = in_valid & in_ready;

    always_comb begin
        load      = 4'b0000;
        out_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            load[k]      = in_hs & (s == 2'(k));
            out_valid[k] = (st[k] == FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Reset wins over any handshake on the same edge.
            for (int k = 0; k < 4; k++) begin
                st[k]  <= EMPTY;
                y_q[k] <= '0;
            end
            cnt_q <= 8'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                case (st[k])
                    EMPTY: begin
                        if (load[k]) begin
                            y_q[k] <= din;
                            st[k]  <= FULL;
                        end
                    end
                    FULL: begin
                        // A load into a FULL channel only happens when its
                        // consumer is ready, so the old beat is never lost.
                        if (load[k]) begin
                            y_q[k] <= din;
                            st[k]  <= FULL;
                        end else if (out_ready[k]) begin
                            st[k]  <= EMPTY;
                        end
                    end
                    default: st[k] <= EMPTY;
                endcase
            end
            if (in_hs) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign y_a      = y_q[0];
    assign y_b      = y_q[1];
    assign y_c      = y_q[2];
    assign y_d      = y_q[3];
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_demux4_reg.sv
// ---------------------------------------------------------------------------
// tb_demux4_reg -- directed bench for demux4_reg (WIDTH = 8).
// Inputs change 1 ns after a rising edge; in_ready is checked 1 ns after
// the inputs settle, registered outputs 1 ns after the next rising edge.
// ---------------------------------------------------------------------------
module tb_demux4_reg;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [1:0]   s;
    logic [W-1:0] din;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y_a, y_b, y_c, y_d;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [7:0]   xfer_cnt;

    demux4_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_a       (y_a),
        .y_b       (y_b),
        .y_c       (y_c),
        .y_d       (y_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [7:0]   exp_cnt;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [1:0]   s;
        logic [W-1:0] din;
        logic         iv;
        logic [3:0]   ordy;
        logic         exp_rdy;
        logic [3:0]   exp_vld;
        logic [W-1:0] ya, yb, yc, yd;
        logic [7:0]   cnt;
    } vec_t;

    vec_t vecs[11];

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ts, input logic [W-1:0] td,
                         input logic tv, input logic [3:0] tr);
        s         = ts;
        din       = td;
        in_valid  = tv;
        out_ready = tr;
    endtask

    function automatic logic [W-1:0] y_of(input int ch);
        case (ch)
            0:       return y_a;
            1:       return y_b;
            2:       return y_c;
            default: return y_d;
        endcase
    endfunction

    task automatic check_all_clear(input string tag);
        check({tag, "_vld"},  32'(out_valid), 32'h0);
        check({tag, "_ya"},   32'(y_a),       32'h0);
        check({tag, "_yb"},   32'(y_b),       32'h0);
        check({tag, "_yc"},   32'(y_c),       32'h0);
        check({tag, "_yd"},   32'(y_d),       32'h0);
        check({tag, "_cnt"},  32'(xfer_cnt),  32'h0);
        check({tag, "_rdy"},  32'(in_ready),  32'h1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        //              s     din    iv    ordy     rdy   vld      ya     yb     yc     yd     cnt
        vecs[0]  = '{2'd2, 8'h5A, 1'b1, 4'b0000, 1'b1, 4'b0100, 8'h00, 8'h00, 8'h5A, 8'h00, 8'd1};
        vecs[1]  = '{2'd1, 8'hFF, 1'b0, 4'b0000, 1'b1, 4'b0100, 8'h00, 8'h00, 8'h5A, 8'h00, 8'd1};
        vecs[2]  = '{2'd0, 8'h11, 1'b1, 4'b0000, 1'b1, 4'b0101, 8'h11, 8'h00, 8'h5A, 8'h00, 8'd2};
        vecs[3]  = '{2'd0, 8'h22, 1'b1, 4'b0000, 1'b0, 4'b0101, 8'h11, 8'h00, 8'h5A, 8'h00, 8'd2};
        vecs[4]  = '{2'd2, 8'h33, 1'b1, 4'b0000, 1'b0, 4'b0101, 8'h11, 8'h00, 8'h5A, 8'h00, 8'd2};
        vecs[5]  = '{2'd3, 8'hC3, 1'b1, 4'b0000, 1'b1, 4'b1101, 8'h11, 8'h00, 8'h5A, 8'hC3, 8'd3};
        vecs[6]  = '{2'd0, 8'h22, 1'b1, 4'b0001, 1'b1, 4'b1101, 8'h22, 8'h00, 8'h5A, 8'hC3, 8'd4};
        vecs[7]  = '{2'd1, 8'h44, 1'b0, 4'b0101, 1'b1, 4'b1000, 8'h22, 8'h00, 8'h5A, 8'hC3, 8'd4};
        vecs[8]  = '{2'd3, 8'h55, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'h22, 8'h00, 8'h5A, 8'h55, 8'd5};
        vecs[9]  = '{2'd1, 8'h66, 1'b1, 4'b1000, 1'b1, 4'b0010, 8'h22, 8'h66, 8'h5A, 8'h55, 8'd6};
        vecs[10] = '{2'd1, 8'h77, 1'b0, 4'b0010, 1'b1, 4'b0000, 8'h22, 8'h66, 8'h5A, 8'h55, 8'd6};

        rst_n = 1'b0;
        drive(2'd0, 8'h00, 1'b0, 4'b0000);
        tick();
        tick();
        check_all_clear("reset");
        rst_n = 1'b1;

        // ---- table-driven vectors ----
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].s, vecs[i].din, vecs[i].iv, vecs[i].ordy);
            #1;
            check($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            tick();
            check($sformatf("v%0d_vld", i), 32'(out_valid), 32'(vecs[i].exp_vld));
            check($sformatf("v%0d_ya", i),  32'(y_a),       32'(vecs[i].ya));
            check($sformatf("v%0d_yb", i),  32'(y_b),       32'(vecs[i].yb));
            check($sformatf("v%0d_yc", i),  32'(y_c),       32'(vecs[i].yc));
            check($sformatf("v%0d_yd", i),  32'(y_d),       32'(vecs[i].yd));
            check($sformatf("v%0d_cnt", i), 32'(xfer_cnt),  32'(vecs[i].cnt));
        end
        exp_cnt = 8'd6;

        // ---- backpressure on channel a held for 5 cycles ----
        drive(2'd0, 8'h11, 1'b1, 4'b0000);
        tick();
        exp_cnt++;
        check("bp_load_ya", 32'(y_a), 32'h11);
        drive(2'd0, 8'h22, 1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_stall%0d_rdy", i), 32'(in_ready), 32'h0);
            tick();
            check($sformatf("bp_stall%0d_ya", i), 32'(y_a), 32'h11);
        end
        check("bp_stall_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        out_ready = 4'b0001;
        #1;
        check("bp_release_rdy", 32'(in_ready), 32'h1);
        tick();
        exp_cnt++;
        check("bp_release_ya",  32'(y_a),       32'h22);
        check("bp_release_vld", 32'(out_valid), 32'h1);
        check("bp_release_cnt", 32'(xfer_cnt),  32'(exp_cnt));

        // ---- s changes while stalled: the select at the handshake edge wins ----
        drive(2'd0, 8'h99, 1'b1, 4'b0000);
        #1;
        check("resel_stall_rdy", 32'(in_ready), 32'h0);
        tick();
        drive(2'd2, 8'h99, 1'b1, 4'b0000);
        #1;
        check("resel_go_rdy", 32'(in_ready), 32'h1);
        tick();
        exp_cnt++;
        check("resel_yc",  32'(y_c),       32'h99);
        check("resel_ya",  32'(y_a),       32'h22);
        check("resel_vld", 32'(out_valid), 32'b0101);
        drive(2'd0, 8'h00, 1'b0, 4'b1111);
        tick();
        check("drain_vld", 32'(out_valid), 32'h0);

        // ---- streaming with all consumers ready ----
        for (int i = 0; i < 8; i++) begin
            drive(2'(i % 4), 8'(i + 1), 1'b1, 4'b1111);
            exp_q.push_back(8'(i + 1));
            #1;
            check($sformatf("st%0d_rdy", i), 32'(in_ready), 32'h1);
            tick();
            exp_cnt++;
            check($sformatf("st%0d_y", i),   32'(y_of(i % 4)),         32'(exp_q.pop_front()));
            check($sformatf("st%0d_vld", i), 32'(out_valid[i % 4]),    32'h1);
        end
        drive(2'd0, 8'h00, 1'b0, 4'b1111);
        tick();
        check("st_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        check("st_vld", 32'(out_valid), 32'h0);

        // ---- counter wrap ----
        begin
            int n;
            n = 256 - int'(exp_cnt);
            for (int i = 0; i < n; i++) begin
                drive(2'(i % 4), 8'(i), 1'b1, 4'b1111);
                tick();
                exp_cnt++;
                if (exp_cnt == 8'hFF) check("wrap_255", 32'(xfer_cnt), 32'hFF);
            end
        end
        check("wrap_0", 32'(xfer_cnt), 32'h0);

        // ---- reset mid-stream discards the in-flight beat ----
        drive(2'd0, 8'hE1, 1'b1, 4'b0000);
        tick();
        check("pre_rst_ya", 32'(y_a), 32'hE1);
        rst_n = 1'b0;
        drive(2'd1, 8'hAB, 1'b1, 4'b0000);
        tick();
        rst_n = 1'b1;
        drive(2'd0, 8'h00, 1'b0, 4'b0000);
        #1;
        check_all_clear("midrst");

        // ---- first beat after reset ----
        drive(2'd3, 8'h07, 1'b1, 4'b0000);
        tick();
        check("post_rst_yd",  32'(y_d),       32'h07);
        check("post_rst_vld", 32'(out_valid), 32'b1000);
        check("post_rst_cnt", 32'(xfer_cnt),  32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux4_reg.md
DEMUX4_REG -- requirements
Module: demux4_reg

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width of input and each output channel.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: s  input  2  destination select; 0->a, 1->b, 2->c, 3->d; sampled only at an input handshake.
REQ-005 SHALL have port: din  input  WIDTH  input data beat.
REQ-006 SHALL have port: in_valid  input  1  producer offers din/s this cycle.
REQ-007 SHALL have port: in_ready  output  1  block accepts din this cycle.
REQ-008 SHALL have port: y_a, y_b, y_c, y_d  output  WIDTH each  registered channel data.
REQ-009 SHALL have port: out_valid  output  4  per-channel data valid; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-010 SHALL have port: out_ready  input  4  per-channel consumer ready, same bit order.
REQ-011 SHALL have port: xfer_cnt  output  8  count of accepted input beats.

Function
REQ-012 SHALL hold one holding register per channel, each with a 2-state FSM: EMPTY (out_valid bit 0) / FULL (out_valid bit 1).
REQ-013 SHALL drive in_ready = !out_valid[s] | out_ready[s], combinationally from current s and state.
REQ-014 SHALL define input handshake as in_valid & in_ready at a rising edge; only then is din written to the channel selected by s.
REQ-015 SHALL define output handshake on channel k as out_valid[k] & out_ready[k] at a rising edge.
REQ-016 SHALL make accepted data visible on the selected y_* with out_valid bit set on the cycle after acceptance (latency 1).
REQ-017 Transitions per channel: EMPTY->FULL on load; FULL->EMPTY on output handshake without load; FULL->FULL with new data on simultaneous output handshake and load (pass-through, no bubble); otherwise hold.
REQ-018 SHALL keep y_* and out_valid of unselected channels unchanged by input activity.
REQ-019 SHALL keep y_k stable while out_valid[k]=1 and out_ready[k]=0 (no overwrite of an unconsumed beat).
REQ-020 SHALL not require s stable between handshakes; s changes while in_valid=1 with in_ready=0 are legal, and the s value at the handshake edge decides the destination.
REQ-021 SHALL preserve per-channel ordering: beats to one channel leave in acceptance order.
REQ-022 SHALL allow channels to drain independently; a stalled channel SHALL NOT block beats addressed to other channels.
REQ-023 SHALL increment xfer_cnt by 1 per input handshake, wrapping 255->0.
REQ-024 SHALL ignore din and s whenever in_valid=0.

Reset
REQ-025 SHALL, on a rising edge with rst_n=0, clear out_valid to 4'b0000, all y_* to 0, xfer_cnt to 0, all FSMs to EMPTY.
REQ-026 SHALL give reset priority over any simultaneous input or output handshake; beats in flight at reset are discarded and not counted.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset release (all channels EMPTY).

Verification
REQ-028 Route: WIDTH=8, s=2, din=8'h5A, in_valid=1 one cycle, out_ready=4'b0000 -> next cycle out_valid=4'b0100, y_c=8'h5A, other y_* 0, xfer_cnt=1.
REQ-029 Backpressure: channel a FULL with 8'h11, out_ready[0]=0, s=0, din=8'h22, in_valid=1 -> in_ready=0, y_a stays 8'h11 for 5 cycles; raise out_ready[0] -> same cycle in_ready=1, next cycle y_a=8'h22, out_valid[0]=1.
REQ-030 Non-blocking: channel a FULL and stalled; send s=3, din=8'hC3 -> in_ready=1, next cycle y_d=8'hC3, out_valid=4'b1001.
REQ-031 Streaming: out_ready=4'b1111, in_valid=1 continuously, s cycling 0,1,2,3 with din 1..8 -> in_ready=1 every cycle, each y_* updates each 4th cycle in order, xfer_cnt=8.
REQ-032 Wrap and reset: 256 accepted beats -> xfer_cnt=0; mid-stream rst_n=0 one cycle with in_valid=1 -> next cycle out_valid=0, all y_*=0, xfer_cnt=0, in_ready=1.
